seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed driver for a multi-digit common-anode/cathode seven-segment display, placed directly downstream of the ALU result path. It accepts a packed hex value through a load strobe and buffers it in a shadow register. It commits the value to the display only at frame boundaries, so digits never tear. It then scans one digit per refresh slot, encoding each 4-bit nibble to segments {a,b,c,d,e,f,g}.

## Interface
- N_DIGITS, 4, number of digits scanned; ≥ 2.
- REFRESH_DIV, 1000, clock cycles per digit slot; ≥ 2.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value.
- value  in  4*N_DIGITS  packed nibbles; digit 0 = value[3:0] (least significant).
- enable  in  1  display enable; low blanks outputs but does not stop scanning.
- seg  out  7  {a,b,c,d,e,f,g}, active-high, registered.
- dig_en  out  N_DIGITS  one-hot digit select, active-high, registered.
- pending  out  1  high while a loaded value waits for the next frame boundary.
- frame_done  out  1  one-cycle pulse per completed scan frame.

## Operation
- Reset values: prescaler=0, digit index=0, display reg=0, shadow reg=0, and all outputs 0 (seg, dig_en, pending, frame_done).
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count the digit index advances. The index runs 0→N_DIGITS-1, then wraps to 0.
- Frame boundary: the terminal-count cycle where the index is N_DIGITS-1.
- load outside a boundary: shadow ← value, pending ← 1. Repeated loads while pending overwrite the shadow; last value wins.
- At a boundary with pending=1: display ← shadow, pending ← 0.
- load coincident with a boundary: display ← value directly and pending ← 0. Any older pending shadow is discarded.
- Segment encoding (nibble → abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- enable=0: seg=0 and dig_en=0. Prescaler, index, load and commit logic run unchanged.
- rst mid-frame: everything returns to reset values on the next edge. A pending value is lost.

## Timing
- Outputs are registered with one-cycle latency. seg/dig_en in cycle t+1 reflect the index and display reg at cycle t.
- Each digit is asserted for exactly REFRESH_DIV consecutive cycles. A frame lasts N_DIGITS*REFRESH_DIV cycles.
- The first cycle after rst deasserts, outputs still show reset values. From the second cycle on, dig_en = 0…01 with seg = encode(0) = 1111110 (if enable=1).
- frame_done is high for the one cycle after each frame boundary edge, which is the same cycle dig_en returns to digit 0.
- Load-to-display latency: at most one frame plus one cycle.
- pending rises the cycle after load. It falls the cycle after the committing boundary.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble of the display reg output seg=0; dig_en still scans normally.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- LEADING_ZERO_BLANK_EN undefined: every digit always shows its nibble, including leading zeros.

## Test plan
- Reset/scan: N_DIGITS=4, REFRESH_DIV=4, release rst, no load → dig_en cycles 0001,0010,0100,1000 for 4 cycles each; seg=1111110 throughout; frame_done pulses every 16 cycles.
- Tear-free commit: load value=16'h12AF mid-frame → pending=1. Displayed digits stay 0 until the boundary; the next frame shows F,A,2,1 on digits 0..3 with seg 1000111,1110111,1101101,0110000. pending then drops.
- Overwrite and coincidence: load 16'h1111, then 16'h2222 before the boundary → only 2222 is displayed. A load of 16'h3333 on a boundary cycle → displayed next frame with pending never asserted.
- Enable gating: drop enable for 10 cycles mid-digit → seg=0 and dig_en=0. On re-enable, scan position matches an uninterrupted reference count.
- Reset mid-operation: pending=1 with display=16'h00C0, assert rst 1 cycle → all outputs 0, and display shows 0 afterwards.
- LEADING_ZERO_BLANK_EN: display 16'h00C0 → digits 3,2 seg=0000000; digit 1 seg=1001110; digit 0 seg=1111110. Without the macro, digits 3 and 2 show 1111110.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed driver for an N_DIGITS seven-segment display. A packed hex
// value is captured on a load strobe into a shadow register and committed to
// the display register only at a frame boundary, so a frame never shows a mix
// of old and new digits. One digit is driven per refresh slot of REFRESH_DIV
// clock cycles.
//
// Parameters
//   N_DIGITS     number of digits scanned (>= 2)
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst         synchronous active-high reset
//   load        single-cycle strobe, captures value
//   value       packed nibbles, digit 0 = value[3:0]
//   enable      display enable; low blanks seg/dig_en, scanning continues
//   seg         {a,b,c,d,e,f,g}, active-high, registered
//   dig_en      one-hot digit select, active-high, registered
//   pending     a loaded value is waiting for the next frame boundary
//   frame_done  one-cycle pulse per completed frame, coincident with dig_en
//               returning to digit 0
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero nibble show seg=0 (digit 0 never blanks).
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]              presc;
  logic [IW-1:0]              idx;
  logic [4*N_DIGITS-1:0]      display;
  logic [4*N_DIGITS-1:0]      shadow;
  logic                       boundary_q;

  logic                       at_tc;
  logic                       boundary;
  logic [N_DIGITS-1:0][3:0]   disp_nib;
  logic [N_DIGITS-1:0]        onehot;
  logic                       blank;

  // Nibble -> {a,b,c,d,e,f,g}, active-high.
  function automatic logic [6:0] encode_hex(input logic [3:0] nib);
    encode_hex = 7'b0000000;
    case (nib)
      4'h0: encode_hex = 7'b1111110;
      4'h1: encode_hex = 7'b0110000;
      4'h2: encode_hex = 7'b1101101;
      4'h3: encode_hex = 7'b1111001;
      4'h4: encode_hex = 7'b0110011;
      4'h5: encode_hex = 7'b1011011;
      4'h6: encode_hex = 7'b1011111;
      4'h7: encode_hex = 7'b1110000;
      4'h8: encode_hex = 7'b1111111;
      4'h9: encode_hex = 7'b1111011;
      4'hA: encode_hex = 7'b1110111;
      4'hB: encode_hex = 7'b0011111;
      4'hC: encode_hex = 7'b1001110;
      4'hD: encode_hex = 7'b0111101;
      4'hE: encode_hex = 7'b1001111;
      4'hF: encode_hex = 7'b1000111;
    endcase
  endfunction

  assign disp_nib = display;
  assign at_tc    = (presc == PRESC_LAST);
  // Last cycle of the last digit slot: the only point where the display
  // register may change.
  assign boundary = at_tc && (idx == IDX_LAST);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Highest nonzero digit; stays 0 for an all-zero value so digit 0 is
  // always lit.
  always_comb begin
    msd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (disp_nib[i] != 4'h0) msd = IW'(i);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      display    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      boundary_q <= 1'b0;
      frame_done <= 1'b0;
      seg        <= '0;
      dig_en     <= '0;
    end else begin
      presc <= at_tc ? '0 : presc + PW'(1);
      if (at_tc) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

      if (boundary) begin
        // A load on the boundary wins over (and discards) any older shadow.
        if (load)         display <= value;
        else if (pending) display <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end

      // Delayed by one extra stage so the pulse lines up with the registered
      // dig_en returning to digit 0.
      boundary_q <= boundary;
      frame_done <= boundary_q;

      seg    <= (enable && !blank) ? encode_hex(disp_nib[idx]) : 7'b0000000;
      dig_en <= enable ? onehot : '0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int F  = N * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          enable = 1'b1;
  logic [6:0]    seg;
  logic [N-1:0]  dig_en;
  logic          pending;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: m = clock edges since reset release, so the scan
  // position before any edge is simply (m / RD) % N.
  int          m = 0;
  logic [15:0] disp_m = '0;
  logic [15:0] shadow_m = '0;
  bit          pend_m = 1'b0;
  bit          last_bnd = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg7_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .enable     (enable),
    .seg        (seg),
    .dig_en     (dig_en),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @%0t: observed=%0h required=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [15:0] d, input int pos, input bit en);
    int top = 0;
    logic [3:0] nib;
    for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'h0) top = i;
    nib = d[4*pos +: 4];
    if (!en) return 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > top) return 7'b0000000;
`endif
    return seg_tab[nib];
  endfunction

  // Drive one cycle, advance the model by one edge, compare every output.
  task automatic tick(input bit r, input bit ld, input logic [15:0] v, input bit en);
    int         pos = (m / RD) % N;
    bit         bnd = ((m % F) == F - 1);
    logic [6:0] e_seg = model_seg(disp_m, pos, en);
    logic [3:0] e_dig = en ? 4'(1 << pos) : 4'b0000;
    bit         e_fd = last_bnd;
    rst = r; load = ld; value = v; enable = en;
    @(posedge clk);
    #1;
    if (r) begin
      m = 0; disp_m = '0; shadow_m = '0; pend_m = 1'b0; last_bnd = 1'b0;
      e_seg = '0; e_dig = '0; e_fd = 1'b0;
    end else begin
      if (bnd) begin
        if (ld)          disp_m = v;
        else if (pend_m) disp_m = shadow_m;
        pend_m = 1'b0;
      end else if (ld) begin
        shadow_m = v;
        pend_m   = 1'b1;
      end
      last_bnd = bnd;
      m++;
    end
    check("seg",        seg,        e_seg);
    check("dig_en",     dig_en,     e_dig);
    check("pending",    pending,    pend_m);
    check("frame_done", frame_done, e_fd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  // Advance until the next edge is frame position pos (bounded to one frame).
  task automatic run_to(input int pos);
    for (int i = 0; i < F && (m % F) != pos; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    // Reset and free-running scan
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    idle(2 * F + 3);

    // Tear-free commit of a mid-frame load
    run_to(5);
    tick(1'b0, 1'b1, 16'h12AF, 1'b1);
    idle(2 * F);

    // Overwrite while pending: last value wins
    run_to(3);
    tick(1'b0, 1'b1, 16'h1111, 1'b1);
    run_to(8);
    tick(1'b0, 1'b1, 16'h2222, 1'b1);
    idle(2 * F);

    // Load exactly on the boundary cycle: pending never rises
    run_to(F - 1);
    tick(1'b0, 1'b1, 16'h3333, 1'b1);
    idle(F + 2);

    // Enable dropped for 10 cycles mid-digit
    run_to(5);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    idle(F + 4);

    // Reset while a value is pending over display 00C0
    run_to(F - 1);
    tick(1'b0, 1'b1, 16'h00C0, 1'b1);
    idle(F + 3);
    tick(1'b0, 1'b1, 16'h1234, 1'b1);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    idle(F + 5);

    // Leading digits of 00C0 (blanked or shown as 0 depending on build)
    run_to(F - 1);
    tick(1'b0, 1'b1, 16'h00C0, 1'b1);
    idle(F + 2);
    run_to(F - 1);
    tick(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(F + 2);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(199) == 0), ($urandom_range(7) == 0),
           16'($urandom), ($urandom_range(9) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
